// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap controller: CSR numbers,
// CSR instruction encodings, mstatus field positions, FSM states and the
// small pure helpers that build CSR accesses and transform mstatus/mtvec.
package trap_ctrl_pkg;

  // CSR instruction op encodings (funct3 of the SYSTEM opcode)
  localparam logic [2:0] CSR_OP_RW = 3'b001;
  localparam logic [2:0] CSR_OP_RS = 3'b010;

  // Machine-mode CSR numbers touched by the controller
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  // mstatus field positions
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // mtvec MODE field value selecting vectored interrupts
  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

  typedef enum logic [3:0] {
    S_IDLE,
    S_T_EPC,
    S_T_CAUSE,
    S_T_TVAL,
    S_T_RDST,
    S_T_WRST,
    S_T_RDVEC,
    S_T_CAP,
    S_REDIRECT,
    S_M_RDEPC,
    S_M_RDST,
    S_M_WRST,
    S_I_CHK,
    S_I_DEC
  } state_t;

  // One access on the shared CSR file port
  typedef struct packed {
    logic [2:0]  op;
    logic [11:0] num;
    logic [4:0]  rs1;
    logic [31:0] wdata;
    logic        we;
  } csr_acc_t;

  function automatic csr_acc_t csr_none();
    csr_acc_t a;
    a = '0;
    return a;
  endfunction

  // Controller writes look like CSRRW with a non-zero source register
  function automatic csr_acc_t csr_write(input logic [11:0] num, input logic [31:0] data);
    csr_acc_t a;
    a.op    = CSR_OP_RW;
    a.num   = num;
    a.rs1   = 5'd1;
    a.wdata = data;
    a.we    = 1'b1;
    return a;
  endfunction

  // Controller reads look like CSRRS x0, i.e. no side effect on the CSR
  function automatic csr_acc_t csr_read(input logic [11:0] num);
    csr_acc_t a;
    a.op    = CSR_OP_RS;
    a.num   = num;
    a.rs1   = 5'd0;
    a.wdata = 32'd0;
    a.we    = 1'b1;
    return a;
  endfunction

  // Trap entry: stash MIE in MPIE, disable interrupts, previous mode = M
  function automatic logic [31:0] mstatus_on_trap(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    r[MSTATUS_MPIE] = s[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  // Trap return: restore MIE from MPIE, MPIE reads back as 1
  function automatic logic [31:0] mstatus_on_mret(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    return r;
  endfunction

  // Handler address: vectored mode only applies to interrupts (cause bit31)
  function automatic logic [31:0] trap_target(input logic [31:0] mtvec, input logic [31:0] cause);
    logic [31:0] base;
    base = {mtvec[31:2], 2'b00};
    if (mtvec[1:0] == MTVEC_MODE_VECTORED && cause[31]) begin
      return base + {cause[29:0], 2'b00};
    end
    return base;
  endfunction

endpackage

// File: rtl/trap_ctrl.sv
// Machine-mode trap/mret/interrupt sequencer. Owns the shared CSR file port:
// in IDLE it lends the port to the pipeline's CSR instructions, otherwise it
// walks mepc/mcause/mtval/mstatus/mtvec one access per cycle and finishes
// with a single-cycle fetch redirect plus the matching completion pulse.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter logic [31:0] IRQ_CAUSE = 32'h8000000B
) (
  input  logic        clk,
  input  logic        rst_n,
  // synchronous exception request
  input  logic        trap_req,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_tval,
  // return-from-trap and external interrupt
  input  logic        mret_req,
  input  logic        irq,
  output logic        trap_ack,
  output logic        mret_ack,
  // pipeline CSR instruction access
  input  logic        ins_req,
  input  logic [2:0]  ins_op,
  input  logic [11:0] ins_num,
  input  logic [4:0]  ins_rs1,
  input  logic [31:0] ins_wdata,
  output logic        ins_grant,
  // shared CSR file port
  output logic [2:0]  csr_op,
  output logic [11:0] csr_num,
  output logic [4:0]  csr_rs1,
  output logic [31:0] csr_wdata,
  output logic        csr_we,
  input  logic [31:0] csr_rdata,
  // pipeline control
  output logic        busy,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  state_t      state_reg, state_next;
  logic [31:0] cause_reg, cause_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] tval_reg, tval_next;
  logic [31:0] redirect_pc_reg, redirect_pc_next;
  logic        is_mret_reg, is_mret_next;
  logic        irq_blocked_reg, irq_blocked_next;
  csr_acc_t    csr_acc;
  logic        grant_c;

  // State and latched trap context; reset abandons any sequence in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= S_IDLE;
      cause_reg       <= 32'd0;
      pc_reg          <= 32'd0;
      tval_reg        <= 32'd0;
      redirect_pc_reg <= 32'd0;
      is_mret_reg     <= 1'b0;
      irq_blocked_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cause_reg       <= cause_next;
      pc_reg          <= pc_next;
      tval_reg        <= tval_next;
      redirect_pc_reg <= redirect_pc_next;
      is_mret_reg     <= is_mret_next;
      irq_blocked_reg <= irq_blocked_next;
    end
  end

  // Arbitration, next-state and per-state CSR access
  always_comb begin
    state_next       = state_reg;
    cause_next       = cause_reg;
    pc_next          = pc_reg;
    tval_next        = tval_reg;
    redirect_pc_next = redirect_pc_reg;
    is_mret_next     = is_mret_reg;
    irq_blocked_next = irq_blocked_reg;
    csr_acc          = csr_none();
    grant_c          = 1'b0;
    trap_ack         = 1'b0;
    mret_ack         = 1'b0;
    redirect_valid   = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (trap_req) begin
          // capture now so the sequence is immune to later input changes
          cause_next   = trap_cause;
          pc_next      = trap_pc;
          tval_next    = trap_tval;
          is_mret_next = 1'b0;
          state_next   = S_T_EPC;
        end else if (mret_req) begin
          is_mret_next = 1'b1;
          state_next   = S_M_RDEPC;
        end else if (irq && !irq_blocked_reg) begin
          state_next = S_I_CHK;
        end else if (ins_req && rst_n) begin
          // the port is combinationally lent, so keep it quiet under reset
          grant_c       = 1'b1;
          csr_acc.op    = ins_op;
          csr_acc.num   = ins_num;
          csr_acc.rs1   = ins_rs1;
          csr_acc.wdata = ins_wdata;
          csr_acc.we    = 1'b1;
          // software touching mstatus may have re-enabled interrupts
          if (ins_num == CSR_MSTATUS && ins_rs1 != 5'd0) begin
            irq_blocked_next = 1'b0;
          end
        end
      end

      S_T_EPC: begin
        csr_acc    = csr_write(CSR_MEPC, pc_reg);
        state_next = S_T_CAUSE;
      end
      S_T_CAUSE: begin
        csr_acc    = csr_write(CSR_MCAUSE, cause_reg);
        state_next = S_T_TVAL;
      end
      S_T_TVAL: begin
        csr_acc    = csr_write(CSR_MTVAL, tval_reg);
        state_next = S_T_RDST;
      end
      S_T_RDST: begin
        csr_acc    = csr_read(CSR_MSTATUS);
        state_next = S_T_WRST;
      end
      S_T_WRST: begin
        // csr_rdata holds mstatus from the previous cycle's read
        csr_acc    = csr_write(CSR_MSTATUS, mstatus_on_trap(csr_rdata));
        state_next = S_T_RDVEC;
      end
      S_T_RDVEC: begin
        csr_acc    = csr_read(CSR_MTVEC);
        state_next = S_T_CAP;
      end
      S_T_CAP: begin
        redirect_pc_next = trap_target(csr_rdata, cause_reg);
        state_next       = S_REDIRECT;
      end

      S_M_RDEPC: begin
        csr_acc    = csr_read(CSR_MEPC);
        state_next = S_M_RDST;
      end
      S_M_RDST: begin
        redirect_pc_next = csr_rdata;
        csr_acc          = csr_read(CSR_MSTATUS);
        state_next       = S_M_WRST;
      end
      S_M_WRST: begin
        csr_acc    = csr_write(CSR_MSTATUS, mstatus_on_mret(csr_rdata));
        state_next = S_REDIRECT;
      end

      S_REDIRECT: begin
        redirect_valid = 1'b1;
        if (is_mret_reg) begin
          mret_ack         = 1'b1;
          irq_blocked_next = 1'b0;
        end else begin
          trap_ack = 1'b1;
        end
        state_next = S_IDLE;
      end

      S_I_CHK: begin
        csr_acc    = csr_read(CSR_MSTATUS);
        state_next = S_I_DEC;
      end
      S_I_DEC: begin
        // MIE clear: park the interrupt until software rewrites mstatus
        if (csr_rdata[MSTATUS_MIE]) begin
          cause_next   = IRQ_CAUSE;
          pc_next      = trap_pc;
          tval_next    = 32'd0;
          is_mret_next = 1'b0;
          state_next   = S_T_EPC;
        end else begin
          irq_blocked_next = 1'b1;
          state_next       = S_IDLE;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign busy        = (state_reg != S_IDLE);
  assign ins_grant   = grant_c;
  assign csr_op      = csr_acc.op;
  assign csr_num     = csr_acc.num;
  assign csr_rs1     = csr_acc.rs1;
  assign csr_wdata   = csr_acc.wdata;
  assign csr_we      = csr_acc.we;
  assign redirect_pc = redirect_pc_reg;

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: hosts a CSR file behind the shared port,
// runs the directed scenarios and a randomized mix, and compares against
// expectations computed from the architectural trap/mret rules.
module tb_trap_ctrl;

  localparam logic [31:0] IRQ_C = 32'h8000000B;

  logic        clk;
  logic        rst_n;
  logic        trap_req;
  logic [31:0] trap_cause, trap_pc, trap_tval;
  logic        mret_req, irq;
  logic        trap_ack, mret_ack;
  logic        ins_req;
  logic [2:0]  ins_op;
  logic [11:0] ins_num;
  logic [4:0]  ins_rs1;
  logic [31:0] ins_wdata;
  logic        ins_grant;
  logic [2:0]  csr_op;
  logic [11:0] csr_num;
  logic [4:0]  csr_rs1;
  logic [31:0] csr_wdata;
  logic        csr_we;
  logic [31:0] csr_rdata;
  logic        busy, redirect_valid;
  logic [31:0] redirect_pc;

  trap_ctrl #(.IRQ_CAUSE(IRQ_C)) dut (
    .clk(clk), .rst_n(rst_n),
    .trap_req(trap_req), .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_tval(trap_tval),
    .mret_req(mret_req), .irq(irq), .trap_ack(trap_ack), .mret_ack(mret_ack),
    .ins_req(ins_req), .ins_op(ins_op), .ins_num(ins_num), .ins_rs1(ins_rs1),
    .ins_wdata(ins_wdata), .ins_grant(ins_grant),
    .csr_op(csr_op), .csr_num(csr_num), .csr_rs1(csr_rs1), .csr_wdata(csr_wdata),
    .csr_we(csr_we), .csr_rdata(csr_rdata),
    .busy(busy), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CSR file environment: read data appears one cycle after the access
  logic [31:0] csr_mem [0:4095];
  logic [31:0] rdata_q;
  logic        poke_en;
  logic [11:0] poke_addr;
  logic [31:0] poke_data;

  always @(posedge clk) begin
    if (poke_en) begin
      csr_mem[poke_addr] <= poke_data;
    end else if (csr_we) begin
      rdata_q <= csr_mem[csr_num];
      case (csr_op)
        3'b001: csr_mem[csr_num] <= csr_wdata;
        3'b010: if (csr_rs1 != 5'd0) csr_mem[csr_num] <= csr_mem[csr_num] | csr_wdata;
        3'b011: if (csr_rs1 != 5'd0) csr_mem[csr_num] <= csr_mem[csr_num] & ~csr_wdata;
        default: ;
      endcase
    end
  end
  assign csr_rdata = rdata_q;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %-22s got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %-22s %0h", tag, got);
    end
  endtask

  // ---- reference model: architectural rules in plain arithmetic ----
  function automatic logic [31:0] m_trap_mstatus(input logic [31:0] s);
    logic [31:0] mie;
    mie = (s >> 3) & 32'd1;
    return (s & ~32'h0000_0088) | (mie << 7) | 32'h0000_1800;
  endfunction

  function automatic logic [31:0] m_mret_mstatus(input logic [31:0] s);
    logic [31:0] mpie;
    mpie = (s >> 7) & 32'd1;
    return (s & ~32'h0000_0008) | (mpie << 3) | 32'h0000_0080;
  endfunction

  function automatic logic [31:0] m_target(input logic [31:0] mtvec, input logic [31:0] cause);
    logic [31:0] base;
    base = mtvec - (mtvec % 32'd4);
    if ((mtvec % 32'd4) == 32'd1 && cause >= 32'h8000_0000)
      return base + 32'd4 * (cause - 32'h8000_0000);
    return base;
  endfunction

  // ---- stimulus helpers (called at a negedge, return at a negedge) ----
  task automatic poke(input logic [11:0] a, input logic [31:0] d);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic wait_ack(input bit want_mret, input bit scramble, output int cyc, output bit got);
    cyc = 0; got = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (want_mret ? mret_ack : trap_ack) got = 1'b1;
      else if (scramble) begin
        trap_cause = $urandom; trap_pc = $urandom; trap_tval = $urandom;
      end
    end
  endtask

  task automatic do_trap(input logic [31:0] mtvec, input logic [31:0] ms, input logic [31:0] cause,
                         input logic [31:0] pc, input logic [31:0] tval, input bit scramble);
    int cyc; bit got;
    logic [31:0] exp_tgt;
    exp_tgt = m_target(mtvec, cause);
    poke(12'h305, mtvec);
    poke(12'h300, ms);
    $display("trap  cause=%h pc=%h tval=%h mtvec=%h mstatus=%h", cause, pc, tval, mtvec, ms);
    trap_req = 1'b1; trap_cause = cause; trap_pc = pc; trap_tval = tval;
    wait_ack(1'b0, scramble, cyc, got);
    check("trap_latency", cyc, 8);
    check("trap_redirect_valid", redirect_valid, 1);
    check("trap_redirect_pc", redirect_pc, exp_tgt);
    trap_req = 1'b0;
    @(negedge clk);
    check("trap_pulse_end", {trap_ack, redirect_valid, busy}, 0);
    check("trap_mepc", csr_mem[12'h341], pc);
    check("trap_mcause", csr_mem[12'h342], cause);
    check("trap_mtval", csr_mem[12'h343], tval);
    check("trap_mstatus", csr_mem[12'h300], m_trap_mstatus(ms));
  endtask

  task automatic do_mret(input logic [31:0] mepc, input logic [31:0] ms);
    int cyc; bit got;
    poke(12'h341, mepc);
    poke(12'h300, ms);
    $display("mret  mepc=%h mstatus=%h", mepc, ms);
    mret_req = 1'b1;
    wait_ack(1'b1, 1'b0, cyc, got);
    check("mret_latency", cyc, 4);
    check("mret_redirect_valid", redirect_valid, 1);
    check("mret_redirect_pc", redirect_pc, mepc);
    mret_req = 1'b0;
    @(negedge clk);
    check("mret_pulse_end", {mret_ack, redirect_valid, busy}, 0);
    check("mret_mstatus", csr_mem[12'h300], m_mret_mstatus(ms));
  endtask

  task automatic ins_access(input logic [2:0] op, input logic [11:0] num, input logic [4:0] rs1,
                            input logic [31:0] wd);
    $display("ins   op=%0d num=%h rs1=%0d wdata=%h", op, num, rs1, wd);
    ins_req = 1'b1; ins_op = op; ins_num = num; ins_rs1 = rs1; ins_wdata = wd;
    #1;
    check("ins_grant", ins_grant, 1);
    check("ins_mirror", {csr_op, csr_num, csr_rs1, csr_wdata, csr_we}, {op, num, rs1, wd, 1'b1});
    @(negedge clk);
    ins_req = 1'b0;
  endtask

  initial begin
    int cyc, nbusy, ngrant, nack;
    bit got;
    logic [31:0] r, ms, cause;
    rst_n = 1'b0;
    trap_req = 0; trap_cause = 0; trap_pc = 0; trap_tval = 0;
    mret_req = 0; irq = 0;
    ins_req = 0; ins_op = 0; ins_num = 0; ins_rs1 = 0; ins_wdata = 0;
    poke_en = 0; poke_addr = 0; poke_data = 0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {busy, redirect_valid, trap_ack, mret_ack, ins_grant, csr_we}, 0);
    check("reset_redirect_pc", redirect_pc, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // directed trap and mret
    do_trap(32'h100, 32'h8, 32'd2, 32'h40, 32'hDEAD, 1'b0);
    do_mret(32'h44, 32'h1880);

    // external interrupt, vectored mtvec: check + decide + 8-cycle trap
    poke(12'h305, 32'h101);
    poke(12'h300, 32'h8);
    $display("irq   vectored mtvec=101 mstatus=8");
    trap_pc = 32'h200; irq = 1'b1;
    wait_ack(1'b0, 1'b0, cyc, got);
    check("irq_latency", cyc, 10);
    check("irq_redirect_pc", redirect_pc, 32'h12C);
    irq = 1'b0;
    @(negedge clk);
    check("irq_mcause", csr_mem[12'h342], IRQ_C);
    check("irq_mepc", csr_mem[12'h341], 32'h200);
    check("irq_mtval", csr_mem[12'h343], 0);
    check("irq_mstatus", csr_mem[12'h300], 32'h1880);

    // interrupt masked: one check, then instructions flow until mstatus write
    poke(12'h300, 32'h0);
    $display("irq   masked, then re-enabled by software");
    irq = 1'b1; trap_pc = 32'h80;
    ins_req = 1'b1; ins_op = 3'b010; ins_num = 12'h341; ins_rs1 = 5'd0; ins_wdata = 32'd0;
    #1;
    check("irq_over_ins", ins_grant, 0);
    nbusy = 0; ngrant = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (ins_grant) ngrant++;
    end
    check("masked_busy_cycles", nbusy, 2);
    check("masked_grant_cycles", ngrant, 6);
    ins_op = 3'b001; ins_num = 12'h300; ins_rs1 = 5'd3; ins_wdata = 32'h8;
    #1;
    check("mstatus_wr_grant", ins_grant, 1);
    @(negedge clk);
    ins_req = 1'b0;
    wait_ack(1'b0, 1'b0, cyc, got);
    check("unmasked_latency", cyc, 10);
    irq = 1'b0;
    @(negedge clk);
    check("unmasked_mcause", csr_mem[12'h342], IRQ_C);
    check("unmasked_mepc", csr_mem[12'h341], 32'h80);

    // simultaneous trap and mret: trap first, mret in the following IDLE cycle
    poke(12'h305, 32'h100);
    poke(12'h300, 32'h8);
    $display("dual  trap_req and mret_req together");
    trap_req = 1'b1; trap_cause = 32'd5; trap_pc = 32'h60; trap_tval = 32'h7;
    mret_req = 1'b1;
    wait_ack(1'b0, 1'b0, cyc, got);
    check("dual_trap_latency", cyc, 8);
    trap_req = 1'b0;
    wait_ack(1'b1, 1'b0, cyc, got);
    check("dual_mret_latency", cyc, 5);
    check("dual_mret_pc", redirect_pc, 32'h60);
    mret_req = 1'b0;
    @(negedge clk);
    check("dual_mstatus", csr_mem[12'h300], m_mret_mstatus(m_trap_mstatus(32'h8)));

    // randomized mix of traps (with input scrambling), mrets and instructions
    for (int k = 0; k < 18; k++) begin
      case ($urandom_range(0, 2))
        0: begin
          r = $urandom;
          cause = $urandom;
          if ($urandom_range(0, 1) == 1) cause = {1'b1, 26'd0, cause[4:0]};
          do_trap({r[31:2], 1'b0, r[0]}, $urandom, cause, $urandom, $urandom, 1'b1);
        end
        1: begin
          ms = $urandom;
          do_mret($urandom, ms);
        end
        default: begin
          r = $urandom;
          ins_access(3'($urandom_range(1, 3)), r[11:0], r[16:12], $urandom);
        end
      endcase
    end

    // asynchronous reset in the middle of a trap
    poke(12'h343, 32'h1234);
    poke(12'h305, 32'h100);
    poke(12'h300, 32'h8);
    $display("reset during trap sequence");
    trap_req = 1'b1; trap_cause = 32'd7; trap_pc = 32'h90; trap_tval = 32'hBEEF;
    repeat (3) @(negedge clk);
    check("pre_reset_busy", busy, 1);
    ins_req = 1'b1; ins_op = 3'b001; ins_num = 12'h341; ins_rs1 = 5'd2; ins_wdata = 32'h55;
    rst_n = 1'b0;
    #1;
    check("rst_ctrl", {busy, redirect_valid, trap_ack, mret_ack, ins_grant, csr_we}, 0);
    check("rst_bus", {csr_op, csr_num, csr_rs1, csr_wdata}, 0);
    check("rst_redirect_pc", redirect_pc, 0);
    trap_req = 1'b0; ins_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    nack = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (trap_ack || mret_ack) nack++;
    end
    check("rst_no_ack", nack, 0);
    check("rst_mtval_kept", csr_mem[12'h343], 32'h1234);
    do_trap(32'h200, 32'h0, 32'd11, 32'h300, 32'h1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
